// File: rtl/ksa_pkg.sv
// Shared definitions for the byte-serial Kogge-Stone add/subtract sequencer.
package ksa_pkg;

   localparam int BYTE_W = 8;

   // Sequencer state encoding (2 bits)
   typedef logic [1:0] state_t;
   localparam state_t IDLE = 2'd0;
   localparam state_t RUN  = 2'd1;
   localparam state_t DONE = 2'd2;

   // Two's-complement overflow of a+b_eff: operands agree in sign, result does not
   function automatic logic ovf_calc(input logic a_msb, input logic b_eff_msb,
                                     input logic sum_msb);
      return (a_msb == b_eff_msb) && (sum_msb != a_msb);
   endfunction

endpackage

// File: rtl/ksa8_cin.sv
// Combinational 8-bit Kogge-Stone adder; carry-in folded into the bit-0 generate.
module ksa8_cin
   import ksa_pkg::*;
(
   input  logic [BYTE_W-1:0] a,
   input  logic [BYTE_W-1:0] b,
   input  logic              cin,
   output logic [BYTE_W-1:0] s,
   output logic              cout
);

   logic [BYTE_W-1:0] p_bit;
   logic [BYTE_W-1:0] g_cur;
   logic [BYTE_W-1:0] p_cur;
   logic [BYTE_W-1:0] g_nxt;
   logic [BYTE_W-1:0] p_nxt;

   // Prefix tree: log2(8)=3 levels at span 1, 2, 4; g_cur[i] ends as carry out of bit i
   always_comb begin
      p_bit    = a ^ b;
      g_cur    = a & b;
      g_cur[0] = (a[0] & b[0]) | (p_bit[0] & cin);
      p_cur    = p_bit;
      g_nxt    = '0;
      p_nxt    = '0;
      for (int lvl = 0; lvl < 3; lvl++) begin
         g_nxt = g_cur;
         p_nxt = p_cur;
         for (int i = (1 << lvl); i < BYTE_W; i++) begin
            g_nxt[i] = g_cur[i] | (p_cur[i] & g_cur[i - (1 << lvl)]);
            p_nxt[i] = p_cur[i] & p_cur[i - (1 << lvl)];
         end
         g_cur = g_nxt;
         p_cur = p_nxt;
      end
      s    = p_bit ^ {g_cur[BYTE_W-2:0], cin};
      cout = g_cur[BYTE_W-1];
   end

endmodule

// File: rtl/ksa_multiword_seq.sv
// Byte-serial WORDS-byte add/subtract sequencer around one shared 8-bit KS slice.
module ksa_multiword_seq
   import ksa_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [8*WORDS-1:0]      a,
   input  logic [8*WORDS-1:0]      b,
   input  logic                    cin,
   input  logic                    sub,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [8*WORDS-1:0]      sum,
   output logic                    cout,
   output logic                    ovf
);

   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int MSB   = 8*WORDS - 1;

   state_t                  state;
   logic [IDX_W-1:0]        idx;
   logic                    carry;
   logic [8*WORDS-1:0]      a_r;
   logic [8*WORDS-1:0]      b_eff_r;
   logic [8*WORDS-1:0]      sum_r;
   logic                    cout_r;
   logic                    ovf_r;

   logic [BYTE_W-1:0]       a_byte;
   logic [BYTE_W-1:0]       b_byte;
   logic [BYTE_W-1:0]       slice_s;
   logic                    slice_cout;
   logic                    last_byte;
   logic                    accept;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign last_byte = (idx == IDX_W'(WORDS - 1));
   assign sum       = sum_r;
   assign cout      = cout_r;
   assign ovf       = ovf_r;

   // Route the operand byte selected by idx into the shared slice
   always_comb begin
      a_byte = '0;
      b_byte = '0;
      for (int i = 0; i < WORDS; i++) begin
         if (idx == IDX_W'(i)) begin
            a_byte = a_r[i*BYTE_W +: BYTE_W];
            b_byte = b_eff_r[i*BYTE_W +: BYTE_W];
         end
      end
   end

   ksa8_cin u_slice (
      .a    (a_byte),
      .b    (b_byte),
      .cin  (carry),
      .s    (slice_s),
      .cout (slice_cout)
   );

   // Operand capture on accept; subtraction stored as the inverted B operand
   always_ff @(posedge clk) begin
      if (accept) begin
         a_r     <= a;
         b_eff_r <= sub ? ~b : b;
      end
   end

   // Sequencer FSM, byte index, inter-byte carry and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         idx    <= '0;
         carry  <= 1'b0;
         sum_r  <= '0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  state <= RUN;
                  idx   <= '0;
                  carry <= sub ? ~cin : cin;
               end
            end
            RUN: begin
               for (int i = 0; i < WORDS; i++) begin
                  if (idx == IDX_W'(i)) begin
                     sum_r[i*BYTE_W +: BYTE_W] <= slice_s;
                  end
               end
               carry <= slice_cout;
               if (last_byte) begin
                  state  <= DONE;
                  idx    <= '0;
                  cout_r <= slice_cout;
                  ovf_r  <= ovf_calc(a_r[MSB], b_eff_r[MSB], slice_s[BYTE_W-1]);
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
